// File: rtl/cla_word_sequencer_if.sv
// Bundle of the request/response signals of cla_word_sequencer.
//
// Handshake: the master raises start with a/b/cin/sub valid; the slave
// accepts on the first rising edge where it is idle (busy=0). While busy=1
// any start is ignored and nothing is queued. done is a one-cycle pulse
// marking sum/cout/ovf as fresh. Those outputs then hold until the next done.
//
// master: drives start, a, b, cin, sub; observes busy, done, sum, cout, ovf
// slave : the reverse
interface cla_word_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/cla_word_sequencer.sv
// Multi-cycle WIDTH-bit adder/subtractor that reuses one 4-bit
// carry-lookahead slice, least-significant nibble first, holding the
// inter-nibble carry in a register.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   bus       slave side of cla_word_sequencer_if (start/a/b/cin/sub in,
//             busy/done/sum/cout/ovf out, all outputs registered)
//   dbg_state current FSM state (0=IDLE, 1=RUN, 2=DONE)
module cla_word_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  cla_word_sequencer_if.slave   bus,
  output logic [1:0]            dbg_state
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [3:0] nib_a, nib_b, g, p, s;
  logic [4:0] c;

  // Nibble selection and the lookahead slice.
  always_comb begin
    nib_a = 4'h0;
    nib_b = 4'h0;
    for (int n = 0; n < NIB; n++) begin
      if (idx_q == IW'(n)) begin
        nib_a = a_q[4*n +: 4];
        nib_b = b_q[4*n +: 4];
      end
    end
    g    = nib_a & nib_b;
    p    = nib_a ^ nib_b;
    c[0] = carry_q;
    // Every carry is a flat sum-of-products of g/p/c0: no ripple inside the slice.
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s    = p ^ c[3:0];
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    work_d  = work_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          // Subtract is A + ~B + 1: invert once here so RUN only ever adds.
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub | bus.cin;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int n = 0; n < NIB; n++) begin
          if (idx_q == IW'(n)) work_d[4*n +: 4] = s;
        end
        carry_d = c[4];
        idx_d   = idx_q + 1'b1;
        if (idx_q == IW'(NIB - 1)) begin
          // Visible outputs only move here, so partial results never leak.
          sum_d   = work_d;
          cout_d  = c[4];
          ovf_d   = c[3] ^ c[4];
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      work_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;
  assign dbg_state = state_q;
endmodule
